// File: rtl/bp_me_lce_cce_monitor.sv
// Passive LCE<->CCE handshake monitor: aggregate fire counters plus per-LCE
// outstanding tracking with sticky overflow/underflow/id/timeout errors.
module bp_me_lce_cce_monitor #(
  parameter int num_lce_p         = 2,
  parameter int lce_id_width_p    = 1,
  parameter int max_outstanding_p = 4,
  parameter int timeout_p         = 1024,
  parameter int ctr_width_p       = 32,
  localparam int out_width_lp     = $clog2(max_outstanding_p + 1),
  localparam int stall_width_lp   = $clog2(timeout_p + 1),
  localparam int pop_width_lp     = $clog2(num_lce_p + 1)
) (
  input  logic                                  clk_i,
  input  logic                                  reset_n_i,
  input  logic [num_lce_p*lce_id_width_p-1:0]   lce_id_i,
  input  logic [num_lce_p-1:0]                  req_v_i,
  input  logic [num_lce_p-1:0]                  req_ready_i,
  input  logic [num_lce_p*lce_id_width_p-1:0]   req_src_id_i,
  input  logic [num_lce_p-1:0]                  resp_v_i,
  input  logic [num_lce_p-1:0]                  resp_ready_i,
  input  logic [num_lce_p-1:0]                  cmd_v_i,
  input  logic [num_lce_p-1:0]                  cmd_yumi_i,
  input  logic [num_lce_p*lce_id_width_p-1:0]   cmd_dst_id_i,
  input  logic [num_lce_p-1:0]                  cmd_done_i,
  input  logic                                  clear_i,
  output logic [ctr_width_p-1:0]                req_count_o,
  output logic [ctr_width_p-1:0]                resp_count_o,
  output logic [ctr_width_p-1:0]                cmd_count_o,
  output logic [num_lce_p*out_width_lp-1:0]     outstanding_o,
  output logic [num_lce_p-1:0]                  err_overflow_o,
  output logic [num_lce_p-1:0]                  err_underflow_o,
  output logic [num_lce_p-1:0]                  err_id_o,
  output logic [num_lce_p-1:0]                  err_timeout_o,
  output logic                                  idle_o
);

  function automatic logic [pop_width_lp-1:0] popcount(input logic [num_lce_p-1:0] v);
    popcount = '0;
    for (int i = 0; i < num_lce_p; i++) begin
      popcount = popcount + pop_width_lp'(v[i]);
    end
  endfunction

  function automatic logic [ctr_width_p-1:0] sat_add(input logic [ctr_width_p-1:0] c,
                                                     input logic [pop_width_lp-1:0] n);
    logic [ctr_width_p+pop_width_lp-1:0] sum;
    sum = {{pop_width_lp{1'b0}}, c} + {{ctr_width_p{1'b0}}, n};
    if (sum > {{pop_width_lp{1'b0}}, {ctr_width_p{1'b1}}}) begin
      sat_add = '1;
    end else begin
      sat_add = sum[ctr_width_p-1:0];
    end
  endfunction

  logic [1:0]                rst_sync_r;
  logic                      rst_n_s;
  logic [num_lce_p-1:0]      req_fire_s, resp_fire_s, cmd_fire_s, done_s;
  logic [out_width_lp-1:0]   out_r     [num_lce_p];
  logic [out_width_lp-1:0]   out_n_s   [num_lce_p];
  logic [stall_width_lp-1:0] stall_r   [num_lce_p];
  logic [stall_width_lp-1:0] stall_n_s [num_lce_p];
  logic [num_lce_p-1:0]      ovf_set_s, unf_set_s, id_set_s, tmo_set_s;

  // Reset asserts asynchronously but releases two edges after reset_n_i rises
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end

  assign rst_n_s     = rst_sync_r[1];
  assign req_fire_s  = req_v_i & req_ready_i;
  assign resp_fire_s = resp_v_i & resp_ready_i;
  assign cmd_fire_s  = cmd_v_i & cmd_yumi_i;
  assign done_s      = cmd_fire_s & cmd_done_i;

  // Per-LCE next outstanding/stall values and error set conditions
  always_comb begin
    for (int i = 0; i < num_lce_p; i++) begin
      out_n_s[i]   = out_r[i];
      ovf_set_s[i] = 1'b0;
      unf_set_s[i] = 1'b0;
      if (req_fire_s[i] && !done_s[i]) begin
        if (out_r[i] == out_width_lp'(max_outstanding_p)) begin
          ovf_set_s[i] = 1'b1;
        end else begin
          out_n_s[i] = out_r[i] + out_width_lp'(1);
        end
      end else if (done_s[i] && !req_fire_s[i]) begin
        if (out_r[i] == '0) begin
          unf_set_s[i] = 1'b1;
        end else begin
          out_n_s[i] = out_r[i] - out_width_lp'(1);
        end
      end else begin
        out_n_s[i] = out_r[i];
      end

      id_set_s[i] = (req_fire_s[i] && (req_src_id_i[i*lce_id_width_p +: lce_id_width_p]
                                       != lce_id_i[i*lce_id_width_p +: lce_id_width_p]))
                 || (cmd_fire_s[i] && (cmd_dst_id_i[i*lce_id_width_p +: lce_id_width_p]
                                       != lce_id_i[i*lce_id_width_p +: lce_id_width_p]));

      // Stall only counts while something is pending and the CCE is silent
      if ((out_r[i] == '0) || cmd_fire_s[i] || clear_i) begin
        stall_n_s[i] = '0;
      end else if (stall_r[i] == stall_width_lp'(timeout_p)) begin
        stall_n_s[i] = stall_r[i];
      end else begin
        stall_n_s[i] = stall_r[i] + stall_width_lp'(1);
      end
      tmo_set_s[i] = (stall_n_s[i] == stall_width_lp'(timeout_p));
    end
  end

  // Counter, outstanding, stall and sticky error registers
  always_ff @(posedge clk_i or negedge rst_n_s) begin
    if (!rst_n_s) begin
      req_count_o     <= '0;
      resp_count_o    <= '0;
      cmd_count_o     <= '0;
      err_overflow_o  <= '0;
      err_underflow_o <= '0;
      err_id_o        <= '0;
      err_timeout_o   <= '0;
      for (int i = 0; i < num_lce_p; i++) begin
        out_r[i]   <= '0;
        stall_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < num_lce_p; i++) begin
        out_r[i]   <= out_n_s[i];
        stall_r[i] <= stall_n_s[i];
      end
      if (clear_i) begin
        req_count_o     <= '0;
        resp_count_o    <= '0;
        cmd_count_o     <= '0;
        err_overflow_o  <= '0;
        err_underflow_o <= '0;
        err_id_o        <= '0;
        err_timeout_o   <= '0;
      end else begin
        req_count_o     <= sat_add(req_count_o, popcount(req_fire_s));
        resp_count_o    <= sat_add(resp_count_o, popcount(resp_fire_s));
        cmd_count_o     <= sat_add(cmd_count_o, popcount(cmd_fire_s));
        err_overflow_o  <= err_overflow_o | ovf_set_s;
        err_underflow_o <= err_underflow_o | unf_set_s;
        err_id_o        <= err_id_o | id_set_s;
        err_timeout_o   <= err_timeout_o | tmo_set_s;
      end
    end
  end

  // Output packing and idle detection
  always_comb begin
    outstanding_o = '0;
    idle_o        = 1'b1;
    for (int i = 0; i < num_lce_p; i++) begin
      outstanding_o[i*out_width_lp +: out_width_lp] = out_r[i];
      if (out_r[i] != '0) begin
        idle_o = 1'b0;
      end else begin
        idle_o = idle_o;
      end
    end
  end

endmodule

// File: tb/tb_bp_me_lce_cce_monitor.sv
// Table-driven, scoreboarded bench for bp_me_lce_cce_monitor (2 LCEs, limit 4,
// timeout 16) plus a 4-bit-counter instance for saturation.
module tb_bp_me_lce_cce_monitor;

  typedef struct {
    logic [1:0]  req, src, resp, cmd, dst, done;
    logic        clr;
    logic [2:0]  o0, o1;
    logic [1:0]  ovf, unf, idf, tmo;
    logic [31:0] reqc, respc, cmdc;
    logic        idle;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  lce_id = 2'b10;
  logic [1:0]  req_v = 2'b00, req_ready = 2'b11, req_src = 2'b10;
  logic [1:0]  resp_v = 2'b00, resp_ready = 2'b11;
  logic [1:0]  cmd_v = 2'b00, cmd_yumi = 2'b11, cmd_dst = 2'b10, cmd_done = 2'b00;
  logic        clear = 1'b0;

  logic [31:0] req_count, resp_count, cmd_count;
  logic [5:0]  outstanding;
  logic [1:0]  err_ovf, err_unf, err_id, err_tmo;
  logic        idle;
  logic [3:0]  s_req_count, s_resp_count, s_cmd_count;
  logic [5:0]  s_outstanding;
  logic [1:0]  s_ovf, s_unf, s_id, s_tmo;
  logic        s_idle;

  int n_vec = 0, n_cmp = 0, n_miscmp = 0;
  vec_t tbl[$];
  vec_t sb[$];

  always #5 clk = ~clk;

  bp_me_lce_cce_monitor #(.num_lce_p(2), .lce_id_width_p(1), .max_outstanding_p(4),
                          .timeout_p(16), .ctr_width_p(32)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .lce_id_i(lce_id),
    .req_v_i(req_v), .req_ready_i(req_ready), .req_src_id_i(req_src),
    .resp_v_i(resp_v), .resp_ready_i(resp_ready),
    .cmd_v_i(cmd_v), .cmd_yumi_i(cmd_yumi), .cmd_dst_id_i(cmd_dst), .cmd_done_i(cmd_done),
    .clear_i(clear), .req_count_o(req_count), .resp_count_o(resp_count), .cmd_count_o(cmd_count),
    .outstanding_o(outstanding), .err_overflow_o(err_ovf), .err_underflow_o(err_unf),
    .err_id_o(err_id), .err_timeout_o(err_tmo), .idle_o(idle));

  bp_me_lce_cce_monitor #(.num_lce_p(2), .lce_id_width_p(1), .max_outstanding_p(4),
                          .timeout_p(16), .ctr_width_p(4)) u_sat (
    .clk_i(clk), .reset_n_i(reset_n), .lce_id_i(lce_id),
    .req_v_i(req_v), .req_ready_i(req_ready), .req_src_id_i(req_src),
    .resp_v_i(resp_v), .resp_ready_i(resp_ready),
    .cmd_v_i(cmd_v), .cmd_yumi_i(cmd_yumi), .cmd_dst_id_i(cmd_dst), .cmd_done_i(cmd_done),
    .clear_i(clear), .req_count_o(s_req_count), .resp_count_o(s_resp_count), .cmd_count_o(s_cmd_count),
    .outstanding_o(s_outstanding), .err_overflow_o(s_ovf), .err_underflow_o(s_unf),
    .err_id_o(s_id), .err_timeout_o(s_tmo), .idle_o(s_idle));

  function automatic vec_t mk(input logic [1:0] req, src, resp, cmd, dst, done,
                              input logic clr, input logic [2:0] o0, o1,
                              input logic [1:0] ovf, unf, idf, tmo,
                              input int reqc, respc, cmdc);
    vec_t v;
    v.req = req; v.src = src; v.resp = resp; v.cmd = cmd; v.dst = dst; v.done = done;
    v.clr = clr; v.o0 = o0; v.o1 = o1; v.ovf = ovf; v.unf = unf; v.idf = idf; v.tmo = tmo;
    v.reqc = reqc; v.respc = respc; v.cmdc = cmdc;
    v.idle = (o0 == 3'd0) && (o1 == 3'd0);
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_miscmp++;
      $display("FAIL %s (step %0d): got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic check_all_zero(input string name);
    chk({name, "_req"}, 0, req_count, 32'd0);
    chk({name, "_resp"}, 0, resp_count, 32'd0);
    chk({name, "_cmd"}, 0, cmd_count, 32'd0);
    chk({name, "_out"}, 0, {26'd0, outstanding}, 32'd0);
    chk({name, "_err"}, 0, {24'd0, err_ovf, err_unf, err_id, err_tmo}, 32'd0);
    chk({name, "_idle"}, 0, {31'd0, idle}, 32'd1);
    chk({name, "_sat_req"}, 0, {28'd0, s_req_count}, 32'd0);
    chk({name, "_sat_idle"}, 0, {31'd0, s_idle}, 32'd1);
  endtask

  // Drive one vector, record its expectation, compare just after the edge
  task automatic run_vec(input vec_t v, input int idx);
    vec_t e;
    req_v = v.req; req_src = v.src; resp_v = v.resp; cmd_v = v.cmd;
    cmd_dst = v.dst; cmd_done = v.done; clear = v.clr;
    sb.push_back(v);
    n_vec++;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("out0", idx, {29'd0, outstanding[2:0]}, {29'd0, e.o0});
    chk("out1", idx, {29'd0, outstanding[5:3]}, {29'd0, e.o1});
    chk("ovf", idx, {30'd0, err_ovf}, {30'd0, e.ovf});
    chk("unf", idx, {30'd0, err_unf}, {30'd0, e.unf});
    chk("idf", idx, {30'd0, err_id}, {30'd0, e.idf});
    chk("tmo", idx, {30'd0, err_tmo}, {30'd0, e.tmo});
    chk("reqc", idx, req_count, e.reqc);
    chk("respc", idx, resp_count, e.respc);
    chk("cmdc", idx, cmd_count, e.cmdc);
    chk("idle", idx, {31'd0, idle}, {31'd0, e.idle});
    @(negedge clk);
  endtask

  initial begin
    logic [1:0] z, s, t;
    z = 2'b00;
    s = 2'b10;
    // Three requests then three completions on LCE0, with a response burst
    tbl.push_back(mk(2'b01, s, 2'b11, z, s, z, 1'b0, 3'd1, 3'd0, z, z, z, z, 1, 2, 0));
    tbl.push_back(mk(2'b01, s, z, z, s, z, 1'b0, 3'd2, 3'd0, z, z, z, z, 2, 2, 0));
    tbl.push_back(mk(2'b01, s, z, z, s, z, 1'b0, 3'd3, 3'd0, z, z, z, z, 3, 2, 0));
    tbl.push_back(mk(z, s, z, 2'b01, s, 2'b01, 1'b0, 3'd2, 3'd0, z, z, z, z, 3, 2, 1));
    tbl.push_back(mk(z, s, z, 2'b01, s, 2'b01, 1'b0, 3'd1, 3'd0, z, z, z, z, 3, 2, 2));
    tbl.push_back(mk(z, s, z, 2'b01, s, 2'b01, 1'b0, 3'd0, 3'd0, z, z, z, z, 3, 2, 3));
    // Five requests on LCE1: the fifth overflows and the count holds at 4
    for (int k = 1; k <= 5; k++)
      tbl.push_back(mk(2'b10, s, z, z, s, z, 1'b0, 3'd0, (k > 4) ? 3'd4 : 3'(k),
                       (k > 4) ? 2'b10 : z, z, z, z, 3 + k, 2, 3));
    for (int k = 1; k <= 4; k++)
      tbl.push_back(mk(z, s, z, 2'b10, s, 2'b10, 1'b0, 3'd0, 3'(4 - k), 2'b10, z, z, z, 8, 2, 3 + k));
    tbl.push_back(mk(z, s, z, z, s, z, 1'b1, 3'd0, 3'd0, z, z, z, z, 0, 0, 0));
    // Underflow at zero, then simultaneous req+done at one
    tbl.push_back(mk(z, s, z, 2'b01, s, 2'b01, 1'b0, 3'd0, 3'd0, z, 2'b01, z, z, 0, 0, 1));
    tbl.push_back(mk(2'b01, s, z, z, s, z, 1'b0, 3'd1, 3'd0, z, 2'b01, z, z, 1, 0, 1));
    tbl.push_back(mk(2'b01, s, z, 2'b01, s, 2'b01, 1'b0, 3'd1, 3'd0, z, 2'b01, z, z, 2, 0, 2));
    tbl.push_back(mk(z, s, z, 2'b01, s, 2'b01, 1'b0, 3'd0, 3'd0, z, 2'b01, z, z, 2, 0, 3));
    tbl.push_back(mk(z, s, z, z, s, z, 1'b1, 3'd0, 3'd0, z, z, z, z, 0, 0, 0));
    // Id errors, and clear racing a request
    tbl.push_back(mk(2'b10, 2'b00, z, z, s, z, 1'b0, 3'd0, 3'd1, z, z, 2'b10, z, 1, 0, 0));
    tbl.push_back(mk(2'b10, s, z, z, s, z, 1'b1, 3'd0, 3'd2, z, z, z, z, 0, 0, 0));
    tbl.push_back(mk(z, s, z, 2'b01, 2'b11, z, 1'b0, 3'd0, 3'd2, z, z, 2'b01, z, 0, 0, 1));
    tbl.push_back(mk(z, s, z, 2'b10, s, 2'b10, 1'b0, 3'd0, 3'd1, z, z, 2'b01, z, 0, 0, 2));
    tbl.push_back(mk(z, s, z, 2'b10, s, 2'b10, 1'b0, 3'd0, 3'd0, z, z, 2'b01, z, 0, 0, 3));
    tbl.push_back(mk(z, s, z, z, s, z, 1'b1, 3'd0, 3'd0, z, z, z, z, 0, 0, 0));
    // Timeout: one pending request, silent CCE, flagged after the 16th cycle
    tbl.push_back(mk(2'b01, s, z, z, s, z, 1'b0, 3'd1, 3'd0, z, z, z, z, 1, 0, 0));
    for (int k = 1; k <= 16; k++) begin
      t = (k == 16) ? 2'b01 : 2'b00;
      tbl.push_back(mk(z, s, z, z, s, z, 1'b0, 3'd1, 3'd0, z, z, z, t, 1, 0, 0));
    end
    tbl.push_back(mk(z, s, z, 2'b01, s, 2'b01, 1'b0, 3'd0, 3'd0, z, z, z, 2'b01, 1, 0, 1));
    tbl.push_back(mk(z, s, z, z, s, z, 1'b1, 3'd0, 3'd0, z, z, z, z, 0, 0, 0));
    // Same, but a non-completing command at cycle 10 restarts the stall count
    tbl.push_back(mk(2'b01, s, z, z, s, z, 1'b0, 3'd1, 3'd0, z, z, z, z, 1, 0, 0));
    for (int k = 1; k <= 9; k++)
      tbl.push_back(mk(z, s, z, z, s, z, 1'b0, 3'd1, 3'd0, z, z, z, z, 1, 0, 0));
    tbl.push_back(mk(z, s, z, 2'b01, s, z, 1'b0, 3'd1, 3'd0, z, z, z, z, 1, 0, 1));
    for (int k = 1; k <= 15; k++)
      tbl.push_back(mk(z, s, z, z, s, z, 1'b0, 3'd1, 3'd0, z, z, z, z, 1, 0, 1));
    tbl.push_back(mk(z, s, z, 2'b01, s, 2'b01, 1'b0, 3'd0, 3'd0, z, z, z, z, 1, 0, 2));
    tbl.push_back(mk(z, s, z, z, s, z, 1'b1, 3'd0, 3'd0, z, z, z, z, 0, 0, 0));
    // Traffic in flight on both ports before the mid-traffic reset
    tbl.push_back(mk(2'b11, s, z, z, s, z, 1'b0, 3'd1, 3'd1, z, z, z, z, 2, 0, 0));
    tbl.push_back(mk(2'b11, s, z, z, s, z, 1'b0, 3'd2, 3'd2, z, z, z, z, 4, 0, 0));

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("release");

    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], i);

    // Reset mid-traffic takes effect with no clock edge
    reset_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(posedge clk);
    @(negedge clk);
    req_v = 2'b00;
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("post_reset");

    // Saturation of a 4-bit counter after 17 requests; 32-bit one keeps counting
    for (int k = 1; k <= 17; k++) begin
      req_v = 2'b01;
      req_src = 2'b10;
      @(posedge clk);
      #1;
      chk("sat_req", k, {28'd0, s_req_count}, (k > 15) ? 32'd15 : 32'(k));
      chk("wide_req", k, req_count, 32'(k));
      @(negedge clk);
    end
    req_v = 2'b00;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
